// File: rtl/led_scan_controller_if.sv
// Bus bundle between the board top level and the seven-segment scan controller.
// The master side writes the message buffer and controls scrolling; the slave
// side (the controller) returns the decoder nibble, anodes and frame pulse.
interface led_scan_controller_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       scroll_en;
  logic [3:0] char;
  logic [3:0] an;
  logic       frame_done;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output scroll_en,
    input  char,
    input  an,
    input  frame_done
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  scroll_en,
    output char,
    output an,
    output frame_done
  );
endinterface

// File: rtl/led_scan_controller.sv
// Four-digit seven-segment scan controller. Holds a 16-nibble message, shows a
// 4-digit window of it through one shared decoder, blanks all anodes at the
// start of every digit slot, and optionally scrolls the window once every
// SCROLL_FRAMES frames.
module led_scan_controller #(
  parameter int unsigned SCAN_DIV      = 16,
  parameter int unsigned BLANK_CYC     = 2,
  parameter int unsigned SCROLL_FRAMES = 8
) (
  input logic                  clk,
  input logic                  reset,
  led_scan_controller_if.slave bus
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrmW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);
  localparam logic [FrmW-1:0] FrmMax   = FrmW'(SCROLL_FRAMES - 1);

  typedef enum logic {StBlank, StOn} phase_e;

  logic [3:0]      msg_q [16];
  logic [3:0]      offset_q, offset_d;
  logic [1:0]      digit_q, digit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [FrmW-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]      char_q, char_d;
  logic            frame_done_q, frame_done_d;
  phase_e          phase_q, phase_d;
  logic [3:0]      rd_idx;
  logic [3:0]      an;
  logic            slot_end;

  // Message buffer: clears on reset, single write port, write on reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        msg_q[i] <= 4'h0;
      end
    end else if (bus.wr_en) begin
      msg_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      offset_q     <= 4'h0;
      digit_q      <= 2'd0;
      cnt_q        <= '0;
      frame_cnt_q  <= '0;
      char_q       <= 4'h0;
      frame_done_q <= 1'b0;
      phase_q      <= StBlank;
    end else begin
      offset_q     <= offset_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      char_q       <= char_d;
      frame_done_q <= frame_done_d;
      phase_q      <= phase_d;
    end
  end

  assign slot_end = (cnt_q == CntMax);

  // Next-state: slot counter, digit advance, frame-end scroll and char load.
  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    digit_d      = digit_q;
    offset_d     = offset_q;
    frame_cnt_d  = frame_cnt_q;
    char_d       = char_q;
    frame_done_d = 1'b0;
    rd_idx       = 4'h0;

    if (slot_end) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
      if (digit_q == 2'd3) begin
        frame_done_d = 1'b1;
        if (bus.scroll_en) begin
          if (frame_cnt_q == FrmMax) begin
            offset_d    = offset_q + 4'd1;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end else begin
          frame_cnt_d = '0;
        end
      end
      // Reads the pre-write buffer, so a same-edge write is not seen until next time.
      rd_idx = offset_d + {2'b00, digit_d};
      char_d = msg_q[rd_idx];
    end

    phase_d = (cnt_d < BlankEnd) ? StBlank : StOn;
  end

  // Anode decode: all off while blanking, otherwise one active-low bit per digit.
  always_comb begin
    an = 4'b1111;
    unique case (phase_q)
      StBlank: an = 4'b1111;
      StOn:    an = ~(4'b1000 >> digit_q);
    endcase
  end

  assign bus.char       = char_q;
  assign bus.an         = an;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_controller.sv
// Directed bench for led_scan_controller with SCAN_DIV=4, BLANK_CYC=1,
// SCROLL_FRAMES=2 (16-cycle frames, scroll step every 2 frames).
module tb_led_scan_controller;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic [3:0] an_tab [16];

  led_scan_controller_if bus ();

  led_scan_controller #(
    .SCAN_DIV      (4),
    .BLANK_CYC     (1),
    .SCROLL_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Advance until the frame position (cycle within the 16-cycle frame) equals t.
  task automatic goto_p(input int t);
    for (int i = 0; i < 17; i++) begin
      if (((cyc - 1) % 16) == t) break;
      step();
    end
  endtask

  task automatic next_p(input int t);
    step();
    goto_p(t);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [3:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    an_tab = '{4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hB, 4'hB, 4'hB,
               4'hF, 4'hD, 4'hD, 4'hD, 4'hF, 4'hE, 4'hE, 4'hE};
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    reset         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 4'h0;
    bus.wr_data   = 4'h0;
    bus.scroll_en = 1'b0;

    // 1: reset values and the first frame's anode sequence / frame pulse.
    repeat (3) step();
    reset = 1'b1;
    cyc   = 1;
    check_eq("rst_char", bus.char, 4'h0);
    for (int c = 1; c <= 17; c++) begin
      check_eq("seq_an", bus.an, an_tab[(c - 1) % 16]);
      check_eq("seq_frame_done", bus.frame_done, (c == 17) ? 1 : 0);
      if (c < 17) step();
    end

    // 2: mapping of buf[0..3] onto anodes 0111, 1011, 1101, 1110.
    wr(4'd0, 4'd1);
    wr(4'd1, 4'd2);
    wr(4'd2, 4'd3);
    wr(4'd3, 4'd4);
    next_p(0);
    for (int k = 0; k < 4; k++) begin
      goto_p(4 * k + 1);
      check_eq("map_an", bus.an, an_tab[4 * k + 1]);
      check_eq("map_char", bus.char, k + 1);
    end

    // 5: write buf[1]=9 on the edge that loads digit 1; old value shows first.
    goto_p(3);
    wr(4'd1, 4'd9);
    check_eq("same_edge_old", bus.char, 4'd2);
    check_eq("same_edge_blank", bus.an, 4'hF);
    goto_p(0);
    goto_p(5);
    check_eq("same_edge_new", bus.char, 4'd9);
    check_eq("same_edge_an", bus.an, 4'hB);

    // 3/4: buf[i]=i, scroll every 2 frames, window wraps through E,F,0,1.
    for (int i = 0; i < 16; i++) wr(4'(i), 4'(i));
    next_p(0);
    bus.scroll_en = 1'b1;
    for (int j = 0; j < 34; j++) begin
      for (int k = 0; k < 4; k++) begin
        goto_p(4 * k);
        check_eq((j == 28) ? "wrap_char" : "scroll_char", bus.char, ((j / 2) + k) % 16);
      end
    end
    // Dropping scroll_en mid-frame cancels the advance that frame end would do.
    bus.scroll_en = 1'b0;
    goto_p(0);
    check_eq("scroll_off_hold", bus.char, 4'd0);

    // 6: build offset 1, then reset while digit 2 is lit; a write on that edge is lost.
    bus.scroll_en = 1'b1;
    next_p(0);
    next_p(0);
    check_eq("pre_rst_offset", bus.char, 4'd1);
    goto_p(9);
    check_eq("pre_rst_an", bus.an, 4'hD);
    check_eq("pre_rst_char", bus.char, 4'd3);
    reset       = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd5;
    bus.wr_data = 4'hF;
    step();
    reset         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.scroll_en = 1'b0;
    cyc           = 1;
    check_eq("mid_rst_an", bus.an, 4'hF);
    check_eq("mid_rst_char", bus.char, 4'h0);
    check_eq("mid_rst_frame_done", bus.frame_done, 1'b0);
    for (int k = 0; k < 4; k++) begin
      goto_p(4 * k + 1);
      check_eq("post_rst_an", bus.an, an_tab[4 * k + 1]);
      check_eq("post_rst_char", bus.char, 4'h0);
    end
    // Offset back at 0: buf[0] appears on digit 0.
    wr(4'd0, 4'd7);
    next_p(0);
    check_eq("post_rst_offset", bus.char, 4'd7);
    // Scroll to offset 2 to view buf[2..5]; buf[5] must still be 0.
    bus.scroll_en = 1'b1;
    repeat (4) next_p(0);
    for (int k = 0; k < 4; k++) begin
      goto_p(4 * k);
      check_eq("post_rst_buf", bus.char, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
